vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Shares the single framebuffer SRAM port between the VGA scanout line prefetch and CPU bus accesses. Driven by the horizontal/vertical pixel counters, it fetches the next visible line into a double-banked line buffer during horizontal blanking, with absolute priority, and grants the CPU all remaining memory cycles. It sits between the VGA timing counters, the line buffer, the CPU bus bridge and the framebuffer RAM.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- WORDS_PER_LINE, 80, framebuffer words per visible line (≤ H_TOTAL−H_ACTIVE−2)
- ADDR_W, 16, word address width
- DATA_W, 16, data width
- FB_BASE, 0, word address of line 0

Ports:
- CLK  in  1  clock; all logic on posedge
- RST_N  in  1  asynchronous, active-low reset
- HCOUNT  in  10  horizontal pixel counter, 0..H_TOTAL−1
- VCOUNT  in  10  vertical line counter, 0..V_TOTAL−1
- CPU_REQ  in  1  CPU request, held until CPU_ACK
- CPU_WE  in  1  1 = write
- CPU_ADDR  in  ADDR_W  word address
- CPU_WDATA  in  DATA_W  write data
- CPU_ACK  out  1  one-cycle completion pulse
- CPU_RDATA  out  DATA_W  read data, valid with CPU_ACK on reads
- MEM_REQ  out  1  memory access issue
- MEM_WE  out  1  write enable
- MEM_ADDR  out  ADDR_W  address
- MEM_WDATA  out  DATA_W  write data
- MEM_READY  in  1  access accepted when MEM_REQ & MEM_READY
- MEM_RDATA  in  DATA_W  read data, valid exactly 1 cycle after an accepted read
- LB_WE  out  1  line-buffer write strobe
- LB_BANK  out  1  bank written (= target line bit 0)
- LB_ADDR  out  7  word index within line
- LB_WDATA  out  DATA_W  line-buffer data
- UNDERRUN  out  1  sticky fetch-deadline miss (only with VGA_ARB_UNDERRUN_EN)

## Operation
- Reset: every output 0, FSM IDLE, word index 0, line base FB_BASE, owner pipe cleared.
- FSM states: IDLE, FETCH, CPU_RD_WAIT.
- Fetch window opens at the cycle HCOUNT == H_ACTIVE when the target line (VCOUNT+1, or 0 when VCOUNT == V_TOTAL−1) is < V_ACTIVE; FSM → FETCH, index 0, LB_BANK = target[0].
- Line base: reset to FB_BASE when target is 0; otherwise previous base + WORDS_PER_LINE (adder only, no multiplier).
- FETCH: MEM_REQ=1, MEM_WE=0, MEM_ADDR = base+index; index increments only on acceptance. After WORDS_PER_LINE acceptances → IDLE.
- Read return: a 1-bit owner tag (fetch/CPU) plus index is registered per accepted read; the next cycle drives either LB_WE/LB_ADDR/LB_WDATA=MEM_RDATA or CPU_ACK/CPU_RDATA.
- CPU: in IDLE with CPU_REQ, issue the CPU access. Write: CPU_ACK in the acceptance cycle (registered, next edge). Read: FSM → CPU_RD_WAIT, CPU_ACK with data 1 cycle after acceptance, then IDLE.
- Simultaneous fetch-window open and CPU_REQ: fetch wins; CPU waits until FETCH ends. A CPU read accepted the cycle before the window opens still returns normally (tagged), with fetch issuing in parallel.
- Deadline: if HCOUNT == H_TOTAL−1 while FETCH is incomplete, abort to IDLE, drop the remaining words; UNDERRUN set (if enabled).

## Timing
- Memory issue rate: at most one access per cycle; read latency fixed at 1.
- Fetch with MEM_READY held 1: WORDS_PER_LINE issue cycles, last LB_WE 1 cycle later.
- CPU write latency, REQ to ACK: 1 cycle minimum. CPU read: 2 cycles minimum.
- CPU_ACK is never asserted twice for one request; CPU_REQ may drop only after ACK.

## Configuration
- VGA_ARB_UNDERRUN_EN defined: sticky UNDERRUN register, cleared only by RST_N.
- Not defined: UNDERRUN tied 0. The abort-at-deadline behaviour is retained.

## Structure
- Package vga_pkg: H_/V_ timing constants, FSM state enum, owner-tag type.
- Sub-module vga_line_fetch: line base register, word index, target-line/bank computation, done flag. The arbiter FSM and return routing stay in the top level.

## Test plan
- Reset mid-FETCH (RST_N low at index 40) → all outputs 0 immediately; next window starts at index 0.
- VCOUNT=9, HCOUNT reaches 640, MEM_READY=1 → MEM_ADDR 800..879 on 80 consecutive cycles; LB_BANK=0; LB_ADDR 0..79 one cycle later.
- CPU write at addr 0x1234 in IDLE → MEM_WE=1, addr 0x1234; CPU_ACK 1 cycle after REQ. CPU read → CPU_ACK + RDATA 2 cycles after REQ.
- CPU_REQ asserted at HCOUNT=640, VCOUNT=9 → no CPU issue until 80 fetches are accepted; then CPU served.
- VCOUNT=479 and 524 → no fetch at 479; fetch of line 0 at 524 from FB_BASE, LB_BANK=0.
- MEM_READY=0 from HCOUNT 650..799 → abort at 799; UNDERRUN=1 and sticky (with macro), 0 without it.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, FSM state and read-owner tag for the framebuffer arbiter.
package vga_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int H_TOTAL        = 800;
  localparam int V_ACTIVE       = 480;
  localparam int V_TOTAL        = 525;
  localparam int WORDS_PER_LINE = 80;
  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int CNT_W          = 10;
  localparam int IDX_W          = 7;
  localparam logic [ADDR_W-1:0] FB_BASE = 16'd0;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_FETCH       = 2'd1,
    ST_CPU_RD_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_CPU   = 1'b1
  } owner_t;

  // Line that will be scanned out after the current one, wrapping at frame end.
  function automatic logic [CNT_W-1:0] next_line(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_line_fetch.sv
// Line prefetch bookkeeping: window detection, target bank, running line base and word index.
module vga_line_fetch
  import vga_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CNT_W-1:0]  i_hcount,
  input  logic [CNT_W-1:0]  i_vcount,
  input  logic              i_accept,
  output logic              o_start,
  output logic              o_bank,
  output logic [ADDR_W-1:0] o_addr,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_last
);

  logic [CNT_W-1:0]  w_target;
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_index;
  logic              r_bank;

  assign w_target = next_line(i_vcount);
  assign o_start  = (i_hcount == CNT_W'(H_ACTIVE)) && (w_target < CNT_W'(V_ACTIVE));

  // The base advances by one line per opened window; line 0 re-anchors it each frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base  <= FB_BASE;
      r_index <= '0;
      r_bank  <= 1'b0;
    end else if (o_start) begin
      r_index <= '0;
      r_bank  <= w_target[0];
      r_base  <= (w_target == '0) ? FB_BASE : r_base + ADDR_W'(WORDS_PER_LINE);
    end else if (i_accept) begin
      r_index <= r_index + 1'b1;
    end
  end

  assign o_bank  = r_bank;
  assign o_index = r_index;
  assign o_addr  = r_base + ADDR_W'(r_index);
  assign o_last  = (r_index == IDX_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: line prefetch in hblank has absolute priority, CPU gets the rest.
// Optional macro VGA_ARB_UNDERRUN_EN adds a sticky UNDERRUN flag for missed fetch deadlines.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CNT_W-1:0]  i_hcount,
  input  logic [CNT_W-1:0]  i_vcount,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_lb_we,
  output logic              o_lb_bank,
  output logic [IDX_W-1:0]  o_lb_addr,
  output logic [DATA_W-1:0] o_lb_wdata,
  output logic              o_underrun
);

  arb_state_t        r_state, w_next_state;
  logic              w_start, w_bank, w_last;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [IDX_W-1:0]  w_index;
  logic              w_fetch_accept, w_deadline, w_abort, w_cpu_issue;
  logic              r_pipe_valid;
  owner_t            r_pipe_owner;
  logic [IDX_W-1:0]  r_pipe_index;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              w_ret_fetch, w_ret_cpu;

  vga_line_fetch u_line_fetch (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_hcount (i_hcount),
    .i_vcount (i_vcount),
    .i_accept (w_fetch_accept),
    .o_start  (w_start),
    .o_bank   (w_bank),
    .o_addr   (w_fetch_addr),
    .o_index  (w_index),
    .o_last   (w_last)
  );

  assign w_fetch_accept = (r_state == ST_FETCH) && i_mem_ready;
  assign w_deadline     = (i_hcount == CNT_W'(H_TOTAL - 1));
  assign w_abort        = (r_state == ST_FETCH) && w_deadline && !(w_fetch_accept && w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // While the ack pulse is out the CPU still holds REQ, so it must not be re-issued.
  always_comb begin
    w_next_state = r_state;
    w_cpu_issue  = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_state = ST_FETCH;
        end else if (i_cpu_req && !r_cpu_ack) begin
          w_cpu_issue = 1'b1;
          o_mem_req   = 1'b1;
          o_mem_we    = i_cpu_we;
          o_mem_addr  = i_cpu_addr;
          o_mem_wdata = i_cpu_we ? i_cpu_wdata : '0;
          if (i_mem_ready && !i_cpu_we) w_next_state = ST_CPU_RD_WAIT;
        end
      end
      ST_FETCH: begin
        o_mem_req  = 1'b1;
        o_mem_addr = w_fetch_addr;
        if (w_fetch_accept && w_last) w_next_state = ST_IDLE;
        else if (w_abort)             w_next_state = ST_IDLE;
      end
      ST_CPU_RD_WAIT: begin
        w_next_state = w_start ? ST_FETCH : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Tag every accepted read so the data returning next cycle goes to the right consumer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe_valid <= 1'b0;
      r_pipe_owner <= OWN_FETCH;
      r_pipe_index <= '0;
    end else begin
      r_pipe_valid <= o_mem_req && i_mem_ready && !o_mem_we;
      r_pipe_owner <= (r_state == ST_FETCH) ? OWN_FETCH : OWN_CPU;
      r_pipe_index <= w_index;
    end
  end

  assign w_ret_fetch = r_pipe_valid && (r_pipe_owner == OWN_FETCH);
  assign w_ret_cpu   = r_pipe_valid && (r_pipe_owner == OWN_CPU);

  assign o_lb_we    = w_ret_fetch;
  assign o_lb_bank  = w_bank;
  assign o_lb_addr  = w_ret_fetch ? r_pipe_index : '0;
  assign o_lb_wdata = w_ret_fetch ? i_mem_rdata  : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_ack <= (w_cpu_issue && i_mem_ready && i_cpu_we) || w_ret_cpu;
      if (w_ret_cpu) r_cpu_rdata <= i_mem_rdata;
    end
  end

  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_rdata = r_cpu_rdata;

`ifdef VGA_ARB_UNDERRUN_EN
  logic r_underrun;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_underrun <= 1'b0;
    else if (w_abort) r_underrun <= 1'b1;
  end

  assign o_underrun = r_underrun;
`else
  assign o_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed line fetches, CPU accesses, deadline abort and reset.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic        cpuReq = 1'b0;
  logic        cpuWe = 1'b0;
  logic [15:0] cpuAddr = '0;
  logic [15:0] cpuWdata = '0;
  logic        memReady = 1'b1;
  logic [15:0] memRdata = '0;
  logic        cpuAck, memReq, memWe, lbWe, lbBank, underrun;
  logic [15:0] cpuRdata, memAddr, memWdata, lbWdata;
  logic [6:0]  lbAddr;

  int   errors = 0;
  int   checks = 0;
  logic runCnt = 1'b0;
  logic pendRd = 1'b0;
  logic [15:0] pendAddr = '0;

`ifdef VGA_ARB_UNDERRUN_EN
  localparam logic EXP_UNDERRUN = 1'b1;
`else
  localparam logic EXP_UNDERRUN = 1'b0;
`endif

  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } issue_t;
  typedef struct { logic bank; logic [6:0] addr; logic [15:0] data; } lb_t;
  typedef struct { logic isRead; logic [15:0] rdata; } ack_t;

  issue_t expIssue[$];
  lb_t    expLb[$];
  ack_t   expAck[$];

  vga_fb_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hcount    (hcount),
    .i_vcount    (vcount),
    .i_cpu_req   (cpuReq),
    .i_cpu_we    (cpuWe),
    .i_cpu_addr  (cpuAddr),
    .i_cpu_wdata (cpuWdata),
    .o_cpu_ack   (cpuAck),
    .o_cpu_rdata (cpuRdata),
    .o_mem_req   (memReq),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .i_mem_ready (memReady),
    .i_mem_rdata (memRdata),
    .o_lb_we     (lbWe),
    .o_lb_bank   (lbBank),
    .o_lb_addr   (lbAddr),
    .o_lb_wdata  (lbWdata),
    .o_underrun  (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memModel(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Free-running pixel counters, stepped just after each rising edge when enabled.
  always @(posedge clk) begin
    if (runCnt) begin
      #1;
      if (hcount == 10'd799) begin
        hcount = '0;
        vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount = hcount + 10'd1;
      end
    end
  end

  // Framebuffer model: read data appears exactly one cycle after an accepted read.
  always @(negedge clk) begin
    pendRd   = memReq && memReady && !memWe;
    pendAddr = memAddr;
  end

  always @(posedge clk) begin
    #1;
    memRdata = pendRd ? memModel(pendAddr) : 16'hDEAD;
  end

  // Monitor: every accepted issue, line-buffer write and CPU ack is matched against the queues.
  always @(negedge clk) begin
    issue_t ei;
    lb_t    el;
    ack_t   ea;
    if (memReq && memReady) begin
      if (expIssue.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_issue: got addr %0h we %0b, required none", memAddr, memWe);
      end else begin
        ei = expIssue.pop_front();
        checkOutput("issue_we", memWe, ei.we);
        checkOutput("issue_addr", memAddr, ei.addr);
        if (ei.we) checkOutput("issue_wdata", memWdata, ei.wdata);
      end
    end
    if (lbWe) begin
      if (expLb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_lb_we: got addr %0h, required none", lbAddr);
      end else begin
        el = expLb.pop_front();
        checkOutput("lb_bank", lbBank, el.bank);
        checkOutput("lb_addr", lbAddr, el.addr);
        checkOutput("lb_wdata", lbWdata, el.data);
      end
    end
    if (cpuAck) begin
      if (expAck.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_cpu_ack: got 1, required 0");
      end else begin
        ea = expAck.pop_front();
        if (ea.isRead) checkOutput("cpu_rdata", cpuRdata, ea.rdata);
      end
    end
  end

  task automatic pushFetch(input int target, input int base, input int nIssue, input int nLb);
    for (int i = 0; i < nIssue; i++) expIssue.push_back('{1'b0, 16'(base + i), 16'h0});
    for (int i = 0; i < nLb; i++)
      expLb.push_back('{target[0], 7'(i), memModel(16'(base + i))});
  endtask

  task automatic setPos(input logic [9:0] v, input logic [9:0] h, input logic run);
    @(posedge clk); #1; runCnt = 1'b0;
    @(posedge clk); #1; vcount = v; hcount = h; runCnt = run;
  endtask

  task automatic waitPos(input logic [9:0] v, input logic [9:0] h);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(vcount == v && hcount == h) && n < 10000);
    if (n >= 10000) begin
      checks++; errors++;
      $display("[TB] FAIL wait_pos: got v=%0d h=%0d, required v=%0d h=%0d", vcount, hcount, v, h);
    end
  endtask

  // One CPU access; latency is edges from REQ assertion to the ACK pulse.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                               input int expLat);
    int   n = 0;
    logic got = 1'b0;
    expIssue.push_back('{we, addr, wdata});
    expAck.push_back('{!we, memModel(addr)});
    @(posedge clk); #1;
    cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
    while (!got && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = cpuAck;
    end
    checkOutput("cpu_ack_latency", n, expLat);
    @(posedge clk); #1;
    cpuReq = 1'b0; cpuWe = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_req"}, memReq, 0);
    checkOutput({tag, "_mem_addr"}, memAddr, 0);
    checkOutput({tag, "_cpu_ack"}, cpuAck, 0);
    checkOutput({tag, "_lb_we"}, lbWe, 0);
    checkOutput({tag, "_lb_bank"}, lbBank, 0);
    checkOutput({tag, "_lb_addr"}, lbAddr, 0);
    checkOutput({tag, "_underrun"}, underrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    // CPU write then read in idle time.
    setPos(10'd9, 10'd100, 1'b0);
    applyStimulus(1'b1, 16'h1234, 16'hCAFE, 1);
    applyStimulus(1'b0, 16'h0042, 16'h0000, 2);

    // Lines 0..10 fetched in order; CPU request arriving with the line-10 window waits for it.
    for (int t = 0; t <= 10; t++) pushFetch(t, t * 80, 80, 80);
    setPos(10'd524, 10'd630, 1'b1);
    waitPos(10'd524, 10'd641);
    checkOutput("line0_first_addr", memAddr, 16'd0);
    checkOutput("line0_bank", lbBank, 1'b0);
    waitPos(10'd0, 10'd641);
    checkOutput("line1_first_addr", memAddr, 16'd80);
    checkOutput("line1_bank", lbBank, 1'b1);
    waitPos(10'd9, 10'd639);
    fork
      applyStimulus(1'b1, 16'h0BEE, 16'hBEEF, 82);
      begin
        waitPos(10'd9, 10'd641);
        checkOutput("line10_first_addr", memAddr, 16'd800);
        checkOutput("line10_bank", lbBank, 1'b0);
        checkOutput("line10_cpu_held", memWe, 1'b0);
        waitPos(10'd9, 10'd720);
        checkOutput("line10_last_addr", memAddr, 16'd879);
        waitPos(10'd9, 10'd721);
        checkOutput("line10_last_lb_we", lbWe, 1'b1);
        checkOutput("line10_last_lb_addr", lbAddr, 7'd79);
        checkOutput("cpu_after_fetch_addr", memAddr, 16'h0BEE);
      end
    join
    waitPos(10'd9, 10'd760);

    // No window for line 480.
    setPos(10'd479, 10'd630, 1'b1);
    waitPos(10'd479, 10'd645);
    checkOutput("no_fetch_479", memReq, 1'b0);
    waitPos(10'd479, 10'd700);

    // Memory stalls from hcount 650: 9 words land, the rest are dropped at 799.
    pushFetch(11, 880, 9, 9);
    setPos(10'd10, 10'd630, 1'b1);
    waitPos(10'd10, 10'd649);
    @(posedge clk); #1; memReady = 1'b0;
    waitPos(10'd10, 10'd700);
    checkOutput("stall_req_held", memReq, 1'b1);
    waitPos(10'd11, 10'd0);
    checkOutput("abort_idle", memReq, 1'b0);
    checkOutput("underrun_set", underrun, EXP_UNDERRUN);
    @(posedge clk); #1; memReady = 1'b1;
    waitPos(10'd11, 10'd20);
    applyStimulus(1'b1, 16'h2000, 16'h0F0F, 1);
    checkOutput("underrun_sticky", underrun, EXP_UNDERRUN);

    // Reset in the middle of a fetch at word 40, then a clean refetch of line 0.
    pushFetch(0, 0, 40, 39);
    setPos(10'd524, 10'd630, 1'b1);
    waitPos(10'd524, 10'd680);
    @(posedge clk); #1;
    rst_n = 1'b0; runCnt = 1'b0;
    #1;
    checkAllZero("midfetch_reset");
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    pushFetch(0, 0, 80, 80);
    setPos(10'd524, 10'd630, 1'b1);
    waitPos(10'd524, 10'd641);
    checkOutput("refetch_first_addr", memAddr, 16'd0);
    waitPos(10'd524, 10'd730);
    runCnt = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("issue_queue_empty", expIssue.size(), 0);
    checkOutput("lb_queue_empty", expLb.size(), 0);
    checkOutput("ack_queue_empty", expAck.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
